accel_spi_reader: RTL and testbench
===================================

ACCEL_SPI_READER -- requirements
Module: accel_spi_reader

Interface
REQ-001 Parameter CLK_DIV, default 25, c50m cycles per SCLK half-period (1 MHz SCLK).
REQ-002 Parameter SAMPLE_PERIOD, default 50000, c50m cycles from one read-transaction start to the next (1 kHz).
REQ-003 Parameter DATA_ADDR, default 6'h32, first accelerometer data register address.
REQ-004 Port c50m, input, 1, sole clock; all logic on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port spi_cs_n, output, 1, chip select, active low.
REQ-007 Port spi_sclk, output, 1, SPI clock, mode 3 (idles high).
REQ-008 Port spi_mosi, output, 1, serial data to sensor.
REQ-009 Port spi_miso, input, 1, serial data from sensor.
REQ-010 Port AccelX, output, 12, latest X sample.
REQ-011 Port AccelY, output, 12, latest Y sample.
REQ-012 Port AccelZ, output, 12, latest Z sample.
REQ-013 Port IMUDataReady, output, 1, new-sample strobe, feeds the averaging stage's clock input.

Function
REQ-014 States SHALL be INIT, WAIT, READ, UPDATE; INIT is entered after reset.
REQ-015 INIT SHALL perform one 16-bit write transaction: byte 8'h2D (write, single), then byte 8'h08 (measure mode), then go to WAIT.
REQ-016 READ SHALL perform one 56-bit transaction: command byte {1'b1, 1'b1, DATA_ADDR}, then six received bytes X0,X1,Y0,Y1,Z0,Z1.
REQ-017 SPI timing: spi_cs_n falls, CLK_DIV cycles later the first SCLK falling edge; MOSI changes only on SCLK falling edges, MSB first; MISO sampled on SCLK rising edges.
REQ-018 After the last rising edge, spi_cs_n SHALL rise CLK_DIV cycles later; spi_sclk SHALL remain high whenever spi_cs_n is high.
REQ-019 spi_cs_n SHALL stay high at least 2*CLK_DIV cycles between transactions.
REQ-020 spi_mosi SHALL be 0 outside transactions and during the six received bytes.
REQ-021 A sample timer SHALL reload to SAMPLE_PERIOD-1 on each READ entry; WAIT->READ when it reaches 0; the first READ starts SAMPLE_PERIOD cycles after INIT completes.
REQ-022 Sample assembly: AccelX = {X1[3:0], X0[7:0]}; likewise Y and Z; upper nibbles discarded.
REQ-023 UPDATE SHALL load AccelX/Y/Z simultaneously, one cycle after spi_cs_n rises at READ end.
REQ-024 IMUDataReady SHALL rise one cycle after the outputs update and stay high exactly 2 cycles; then return to WAIT.
REQ-025 AccelX/Y/Z SHALL hold between updates; partial data SHALL never appear on outputs.
REQ-026 Parameter legality: SAMPLE_PERIOD SHALL exceed 60*2*CLK_DIV; otherwise behaviour undefined (simulation assertion required).
REQ-027 spi_miso SHALL be ignored outside rising-edge sample points.

Reset
REQ-028 While reset is high: spi_cs_n=1, spi_sclk=1, spi_mosi=0, AccelX/Y/Z=12'h000, IMUDataReady=0, state=INIT, timers/bit counters=0.
REQ-029 Reset mid-transaction SHALL abort on the next clock edge (spi_cs_n high, no output update, no strobe); INIT repeats after release.
REQ-030 Reset during an IMUDataReady pulse SHALL force it low on the next edge.

Verification
REQ-031 Release reset -> first cs_n fall within 2 cycles; MOSI bytes 8'h2D,8'h08; 16 SCLK falls each 2*CLK_DIV apart.
REQ-032 Sensor model returns 34,12,CD,AB,FF,0F -> AccelX=12'h234, AccelY=12'hBCD, AccelZ=12'hFFF; IMUDataReady high 2 cycles, one cycle after outputs change.
REQ-033 Run 3 samples -> cs_n falling edges of consecutive READs exactly SAMPLE_PERIOD apart; outputs constant between strobes.
REQ-034 Assert reset at bit 30 of a READ -> cs_n high next cycle, outputs 0, no strobe; INIT write repeats after release.
REQ-035 MISO toggled away from SCLK rising edges (model drives garbage mid-low-phase) -> assembled values unaffected.
REQ-036 Check sclk==1 whenever cs_n==1, and mosi stable while sclk high, over the whole run.

Source files
------------

// File: rtl/accel_spi_reader.sv
// SPI master for a 3-axis accelerometer: puts the sensor in measure mode once, then
// reads six data bytes every SAMPLE_PERIOD cycles and publishes 12-bit X/Y/Z samples.
module accel_spi_reader #(
    parameter int         CLK_DIV       = 25,
    parameter int         SAMPLE_PERIOD = 50000,
    parameter logic [5:0] DATA_ADDR     = 6'h32
) (
    input  logic        c50m,
    input  logic        reset,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [11:0] AccelX,
    output logic [11:0] AccelY,
    output logic [11:0] AccelZ,
    output logic        IMUDataReady
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(SAMPLE_PERIOD - 1);
    localparam logic [55:0]   INIT_FRAME   = {8'h2D, 8'h08, 40'd0};
    localparam logic [55:0]   READ_FRAME   = {2'b11, DATA_ADDR, 48'd0};
    localparam logic [6:0]    INIT_HALVES  = 7'd32;
    localparam logic [6:0]    READ_HALVES  = 7'd112;

    typedef enum logic [1:0] {INIT, WAIT, READ, UPDATE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [6:0]    half_q, half_d;
    logic          active_q, active_d;
    logic [55:0]   shift_q, shift_d;
    logic [6:0]    rx_byte_q, rx_byte_d;
    logic [7:0]    x0_q, x0_d, y0_q, y0_d, z0_q, z0_d;
    logic [3:0]    x1_q, x1_d, y1_q, y1_d, z1_q, z1_d;
    logic          cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    upd_q, upd_d;
    logic [11:0]   ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic          rdy_q, rdy_d;
    logic [6:0]    last_half;
    logic [7:0]    new_byte;

    assign last_half = (state_q == INIT) ? INIT_HALVES : READ_HALVES;
    assign new_byte  = {rx_byte_q, spi_miso};

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        half_d    = half_q;
        active_d  = active_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        x0_d = x0_q; y0_d = y0_q; z0_d = z0_q;
        x1_d = x1_q; y1_d = y1_q; z1_d = z1_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        timer_d   = (timer_q != '0) ? timer_q - TW'(1) : '0;
        upd_d     = upd_q;
        ax_d = ax_q; ay_d = ay_q; az_d = az_q;
        rdy_d     = rdy_q;

        if (active_q) begin
            div_d = div_q + DW'(1);
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                half_d = half_q + 7'd1;
                if (half_q == last_half) begin
                    active_d = 1'b0;
                    cs_n_d   = 1'b1;
                    mosi_d   = 1'b0;
                    if (state_q == INIT) begin
                        state_d = WAIT;
                        timer_d = TIMER_RELOAD;
                    end else begin
                        state_d = UPDATE;
                        upd_d   = 2'd0;
                    end
                end else if (!half_q[0]) begin
                    sclk_d  = 1'b0;
                    mosi_d  = shift_q[55];
                    shift_d = {shift_q[54:0], 1'b0};
                end else begin
                    // Rising edge: the only point where spi_miso is looked at.
                    sclk_d    = 1'b1;
                    rx_byte_d = new_byte[6:0];
                    if (state_q == READ && half_q[3:1] == 3'd7) begin
                        case (half_q[6:4])
                            3'd1:    x0_d = new_byte;
                            3'd2:    x1_d = new_byte[3:0];
                            3'd3:    y0_d = new_byte;
                            3'd4:    y1_d = new_byte[3:0];
                            3'd5:    z0_d = new_byte;
                            3'd6:    z1_d = new_byte[3:0];
                            default: ;
                        endcase
                    end
                end
            end
        end else begin
            case (state_q)
                INIT: begin
                    cs_n_d   = 1'b0;
                    active_d = 1'b1;
                    div_d    = '0;
                    half_d   = '0;
                    shift_d  = INIT_FRAME;
                end
                WAIT: begin
                    if (timer_q == '0) begin
                        state_d  = READ;
                        cs_n_d   = 1'b0;
                        active_d = 1'b1;
                        div_d    = '0;
                        half_d   = '0;
                        shift_d  = READ_FRAME;
                        timer_d  = TIMER_RELOAD;
                    end
                end
                UPDATE: begin
                    // Outputs load together, strobe follows one cycle later for two cycles.
                    upd_d = upd_q + 2'd1;
                    case (upd_q)
                        2'd0: begin
                            ax_d = {x1_q, x0_q};
                            ay_d = {y1_q, y0_q};
                            az_d = {z1_q, z0_q};
                        end
                        2'd1: rdy_d = 1'b1;
                        2'd3: begin
                            rdy_d   = 1'b0;
                            state_d = WAIT;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge c50m) begin
        assert (SAMPLE_PERIOD > 120 * CLK_DIV)
            else $error("accel_spi_reader: SAMPLE_PERIOD must exceed 120*CLK_DIV");
        if (reset) begin
            state_q   <= INIT;
            div_q     <= '0;
            half_q    <= '0;
            active_q  <= 1'b0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            x0_q <= '0; y0_q <= '0; z0_q <= '0;
            x1_q <= '0; y1_q <= '0; z1_q <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            timer_q   <= '0;
            upd_q     <= '0;
            ax_q <= '0; ay_q <= '0; az_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            half_q    <= half_d;
            active_q  <= active_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            x0_q <= x0_d; y0_q <= y0_d; z0_q <= z0_d;
            x1_q <= x1_d; y1_q <= y1_d; z1_q <= z1_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            timer_q   <= timer_d;
            upd_q     <= upd_d;
            ax_q <= ax_d; ay_q <= ay_d; az_q <= az_d;
            rdy_q     <= rdy_d;
        end
    end

    assign spi_cs_n     = cs_n_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign AccelX       = ax_q;
    assign AccelY       = ay_q;
    assign AccelZ       = az_q;
    assign IMUDataReady = rdy_q;
endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: a behavioural SPI sensor model feeds random register
// bytes, and each sample is compared with values rebuilt from those bytes.
module tb_accel_spi_reader;
    localparam int         CLK_DIV       = 4;
    localparam int         SAMPLE_PERIOD = 600;
    localparam logic [5:0] DATA_ADDR     = 6'h32;
    localparam int         BUDGET        = 2000;

    logic        c50m = 1'b0;
    logic        reset = 1'b1;
    logic        spi_cs_n, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;
    logic [11:0] AccelX, AccelY, AccelZ;
    logic        IMUDataReady;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint init_rise = 0;
    longint prev_fall = 0;

    accel_spi_reader #(
        .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .DATA_ADDR(DATA_ADDR)
    ) dut (
        .c50m(c50m), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .AccelX(AccelX), .AccelY(AccelY),
        .AccelZ(AccelZ), .IMUDataReady(IMUDataReady)
    );

    always #10 c50m = ~c50m;
    always @(posedge c50m) cyc <= cyc + 1;

    // Sensor model: mode 3 slave, MISO changes on SCLK falls, optional garbage between samples.
    logic [7:0] tx_bytes [6];
    logic [7:0] mosi_bytes [$];
    longint     fall_times [$];
    longint     rise_times [$];
    bit         garbage_en = 1'b0;
    logic       sclk_prev = 1'b1, cs_prev = 1'b1, mosi_prev = 1'b0, rst_prev = 1'b1;
    logic [7:0] mosi_sh = 8'h00;
    int         fall_cnt = 0;
    int         low_cyc = 0;
    logic       cur_bit = 1'b0;

    always @(negedge c50m) begin
        if (cs_prev && !spi_cs_n) begin
            fall_cnt = 0;
            mosi_bytes.delete();
            fall_times.delete();
            rise_times.delete();
        end
        if (!spi_cs_n && sclk_prev && !spi_sclk) begin
            if (fall_cnt >= 8 && fall_cnt < 56)
                cur_bit = tx_bytes[(fall_cnt - 8) / 8][7 - ((fall_cnt - 8) % 8)];
            else
                cur_bit = garbage_en ? 1'($urandom) : 1'b0;
            fall_cnt++;
            low_cyc = 0;
            spi_miso = cur_bit;
            fall_times.push_back(cyc);
        end else if (!spi_cs_n && !sclk_prev && spi_sclk) begin
            mosi_sh = {mosi_sh[6:0], spi_mosi};
            rise_times.push_back(cyc);
            if (rise_times.size() % 8 == 0) mosi_bytes.push_back(mosi_sh);
            if (garbage_en) spi_miso = 1'($urandom);
        end else if (!spi_cs_n && !spi_sclk) begin
            low_cyc++;
            spi_miso = (garbage_en && low_cyc == 1) ? ~cur_bit : cur_bit;
        end else if (garbage_en) begin
            spi_miso = 1'($urandom);
        end

        if (!reset && !rst_prev) begin
            checks++;
            if (spi_cs_n && !spi_sclk) begin
                errors++;
                $display("FAIL sclk_idle cyc=%0d sclk=%b required 1 while cs_n high", cyc, spi_sclk);
            end
            checks++;
            if (spi_cs_n && spi_mosi) begin
                errors++;
                $display("FAIL mosi_idle cyc=%0d mosi=%b required 0 while cs_n high", cyc, spi_mosi);
            end
            checks++;
            if (sclk_prev && spi_sclk && spi_mosi !== mosi_prev) begin
                errors++;
                $display("FAIL mosi_stable cyc=%0d mosi=%b required %b while sclk high", cyc, spi_mosi, mosi_prev);
            end
        end
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
        mosi_prev = spi_mosi;
        rst_prev  = reset;
    end

    function automatic logic [11:0] ref_sample(logic [7:0] lo, logic [7:0] hi);
        return 12'((int'(hi) % 16) * 256 + int'(lo));
    endfunction

    // Follows one READ from WAIT through the strobe; gathers observations, judges nothing.
    task automatic capture_read(output bit ok, output longint t_fall, output longint t_rise,
                                output logic [11:0] xn, output logic [11:0] yn,
                                output logic [11:0] zn, output logic [3:0] rdy_pat,
                                output bit stable);
        logic [11:0] xo, yo, zo;
        int n;
        ok = 1'b0; stable = 1'b1; rdy_pat = 4'h0; t_fall = 0; t_rise = 0;
        xn = 12'h0; yn = 12'h0; zn = 12'h0;
        xo = AccelX; yo = AccelY; zo = AccelZ;
        n = 0;
        while (spi_cs_n !== 1'b0 && n < BUDGET) begin
            @(negedge c50m); n++;
            if (AccelX !== xo || AccelY !== yo || AccelZ !== zo || IMUDataReady !== 1'b0) stable = 1'b0;
        end
        if (n >= BUDGET) return;
        t_fall = cyc;
        n = 0;
        while (spi_cs_n !== 1'b1 && n < BUDGET) begin
            @(negedge c50m); n++;
            if (AccelX !== xo || AccelY !== yo || AccelZ !== zo || IMUDataReady !== 1'b0) stable = 1'b0;
        end
        if (n >= BUDGET) return;
        t_rise = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge c50m);
            if (i == 0) begin xn = AccelX; yn = AccelY; zn = AccelZ; end
            rdy_pat[i] = IMUDataReady;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge c50m);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b need 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b need 1", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b need 0", spi_mosi); end
        checks++; if (AccelX !== 12'h000) begin errors++; $display("FAIL reset_x got %h need 000", AccelX); end
        checks++; if (AccelY !== 12'h000) begin errors++; $display("FAIL reset_y got %h need 000", AccelY); end
        checks++; if (AccelZ !== 12'h000) begin errors++; $display("FAIL reset_z got %h need 000", AccelZ); end
        checks++; if (IMUDataReady !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b need 0", IMUDataReady); end
        $display("reset: outputs idle x=%h y=%h z=%h", AccelX, AccelY, AccelZ);
    endtask

    task automatic test_init_write(input string tag);
        longint t_rel, t_fall;
        int n, bad;
        logic [15:0] got;
        @(negedge c50m);
        reset = 1'b0;
        t_rel = cyc;
        n = 0;
        while (spi_cs_n !== 1'b0 && n < 20) begin @(negedge c50m); n++; end
        t_fall = cyc;
        checks++;
        if (spi_cs_n !== 1'b0 || t_fall - t_rel > 2) begin
            errors++; $display("FAIL %s_cs_fall delay got %0d cycles need <=2", tag, t_fall - t_rel);
        end
        n = 0;
        while (spi_cs_n !== 1'b1 && n < BUDGET) begin @(negedge c50m); n++; end
        init_rise = cyc;
        checks++;
        if (n >= BUDGET) begin errors++; $display("FAIL %s_cs_rise timeout after %0d cycles", tag, n); end
        got = (mosi_bytes.size() == 2) ? {mosi_bytes[0], mosi_bytes[1]} : 16'hxxxx;
        checks++;
        if (got !== 16'h2D08) begin errors++; $display("FAIL %s_mosi got %h (%0d bytes) need 2d08", tag, got, mosi_bytes.size()); end
        checks++;
        if (fall_times.size() != 16) begin errors++; $display("FAIL %s_sclk_falls got %0d need 16", tag, fall_times.size()); end
        else begin
            checks++;
            if (fall_times[0] - t_fall != CLK_DIV) begin
                errors++; $display("FAIL %s_first_fall got %0d need %0d", tag, fall_times[0] - t_fall, CLK_DIV);
            end
            bad = 0;
            for (int i = 1; i < 16; i++) if (fall_times[i] - fall_times[i-1] != 2 * CLK_DIV) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL %s_fall_spacing got %0d bad gaps need 0", tag, bad); end
            checks++;
            if (rise_times.size() != 16 || init_rise - rise_times[rise_times.size()-1] != CLK_DIV) begin
                errors++; $display("FAIL %s_cs_rise_delay got %0d need %0d", tag,
                                   init_rise - rise_times[rise_times.size()-1], CLK_DIV);
            end
        end
        $display("%s: write %h, %0d sclk falls, cs_n %0d..%0d", tag, got, fall_times.size(), t_fall, init_rise);
    endtask

    // One READ with given bytes, every aspect of it compared to the reference.
    task automatic run_sample(input string tag, input bit check_period, input longint ref_time);
        bit ok, stable;
        longint t_fall, t_rise;
        logic [11:0] xn, yn, zn, xe, ye, ze;
        logic [3:0] rdy_pat;
        logic [7:0] cmd_exp;
        int nz;
        xe = ref_sample(tx_bytes[0], tx_bytes[1]);
        ye = ref_sample(tx_bytes[2], tx_bytes[3]);
        ze = ref_sample(tx_bytes[4], tx_bytes[5]);
        cmd_exp = 8'(192 + int'(DATA_ADDR));
        capture_read(ok, t_fall, t_rise, xn, yn, zn, rdy_pat, stable);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_timeout no complete READ within %0d cycles", tag, BUDGET); return; end
        if (check_period) begin
            checks++;
            if (t_fall - ref_time != SAMPLE_PERIOD) begin
                errors++; $display("FAIL %s_period got %0d need %0d", tag, t_fall - ref_time, SAMPLE_PERIOD);
            end
        end
        prev_fall = t_fall;
        nz = 0;
        for (int i = 1; i < mosi_bytes.size(); i++) if (mosi_bytes[i] != 8'h00) nz++;
        checks++;
        if (mosi_bytes.size() != 7 || mosi_bytes[0] !== cmd_exp || nz != 0) begin
            errors++; $display("FAIL %s_mosi got %0d bytes cmd %h nonzero %0d need 7 bytes cmd %h nonzero 0",
                               tag, mosi_bytes.size(), mosi_bytes.size() > 0 ? mosi_bytes[0] : 8'hxx, nz, cmd_exp);
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL %s_hold outputs or strobe moved before update, need constant", tag); end
        checks++; if (xn !== xe) begin errors++; $display("FAIL %s_x got %h need %h", tag, xn, xe); end
        checks++; if (yn !== ye) begin errors++; $display("FAIL %s_y got %h need %h", tag, yn, ye); end
        checks++; if (zn !== ze) begin errors++; $display("FAIL %s_z got %h need %h", tag, zn, ze); end
        checks++;
        if (rdy_pat !== 4'b0110) begin errors++; $display("FAIL %s_strobe got %b need 0110", tag, rdy_pat); end
        $display("%s: cs_n fall %0d x=%h y=%h z=%h strobe=%b", tag, t_fall, xn, yn, zn, rdy_pat);
    endtask

    task automatic test_read_fixed();
        tx_bytes[0] = 8'h34; tx_bytes[1] = 8'h12; tx_bytes[2] = 8'hCD;
        tx_bytes[3] = 8'hAB; tx_bytes[4] = 8'hFF; tx_bytes[5] = 8'h0F;
        run_sample("read_fixed", 1'b1, init_rise);
    endtask

    task automatic test_sample_period();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
            run_sample($sformatf("period_%0d", s), 1'b1, prev_fall);
        end
    endtask

    task automatic test_miso_glitch();
        garbage_en = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
            run_sample($sformatf("glitch_%0d", s), 1'b1, prev_fall);
        end
        garbage_en = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int n;
        bit seen_rdy;
        for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
        n = 0;
        while (spi_cs_n !== 1'b0 && n < BUDGET) begin @(negedge c50m); n++; end
        checks++;
        if (n >= BUDGET) begin errors++; $display("FAIL midreset_timeout no READ within %0d cycles", BUDGET); end
        repeat (CLK_DIV * 61) @(negedge c50m);
        reset = 1'b1;
        @(negedge c50m);
        checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL midreset_cs_n got %b need 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b1) begin errors++; $display("FAIL midreset_sclk got %b need 1", spi_sclk); end
        checks++;
        if ({AccelX, AccelY, AccelZ} !== 36'h0) begin
            errors++; $display("FAIL midreset_outputs got %h %h %h need 000 000 000", AccelX, AccelY, AccelZ);
        end
        seen_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge c50m);
            if (IMUDataReady !== 1'b0 || spi_cs_n !== 1'b1) seen_rdy = 1'b1;
        end
        checks++;
        if (seen_rdy) begin errors++; $display("FAIL midreset_quiet got strobe/cs activity during reset need none"); end
        $display("midreset: aborted at cycle %0d, cs_n=%b outputs cleared", cyc, spi_cs_n);
        test_init_write("reinit");
    endtask

    task automatic test_reset_strobe();
        int n;
        for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
        n = 0;
        while (IMUDataReady !== 1'b1 && n < BUDGET) begin @(negedge c50m); n++; end
        checks++;
        if (n >= BUDGET) begin errors++; $display("FAIL rdyreset_timeout no strobe within %0d cycles", BUDGET); end
        reset = 1'b1;
        @(negedge c50m);
        checks++;
        if (IMUDataReady !== 1'b0) begin errors++; $display("FAIL rdyreset_strobe got %b need 0", IMUDataReady); end
        $display("rdyreset: strobe=%b one cycle after reset", IMUDataReady);
        repeat (3) @(negedge c50m);
        reset = 1'b0;
        repeat (3) @(negedge c50m);
    endtask

    initial begin
        test_reset();
        test_init_write("init");
        test_read_fixed();
        test_sample_period();
        test_miso_glitch();
        test_reset_mid_read();
        test_reset_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
